// File: rtl/tlc_ped_ctrl.sv
// Pedestrian crossing controller downstream of the vehicle traffic light.
// Latches button requests, runs WALK / flashing clearance while red, flags illegal lamps.
module tlc_ped_ctrl #(
  parameter int WALK_CYC  = 6,
  parameter int FLASH_CYC = 4,
  parameter int CNT_W     = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_red,
  input  logic             i_yellow,
  input  logic             i_green,
  input  logic             i_ped_btn,
  output logic             o_walk,
  output logic             o_dont_walk,
  output logic [CNT_W-1:0] o_countdown,
  output logic             o_ped_wait,
  output logic             o_fault
);

  typedef enum logic [1:0] {S_IDLE, S_WALK, S_CLEAR, S_FAULT} state_t;

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_timer, w_timer_next;
  logic             r_sync1, r_sync2, r_btn_d, r_red_d;
  logic [1:0]       r_bad_cnt, w_bad_next;
  logic             r_walk, r_dont_walk, r_ped_wait, r_fault;
  logic [CNT_W-1:0] r_countdown;

  logic             w_press, w_red_rise, w_legal, w_fault_entry;
  logic             w_walk_next, w_dont_walk_next, w_ped_wait_next, w_fault_next;
  logic [CNT_W-1:0] w_countdown_next;

  always_comb begin
    w_press    = r_sync2 & ~r_btn_d;
    w_red_rise = i_red & ~r_red_d;
    w_legal    = ({i_red, i_yellow, i_green} == 3'b100) ||
                 ({i_red, i_yellow, i_green} == 3'b010) ||
                 ({i_red, i_yellow, i_green} == 3'b001);
    if (w_legal)                w_bad_next = 2'd0;
    else if (r_bad_cnt == 2'd3) w_bad_next = 2'd3;
    else                        w_bad_next = r_bad_cnt + 2'd1;
    // Also holds FAULT while the lamps stay illegal
    w_fault_entry = (w_bad_next >= 2'd2);
  end

  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    if (w_fault_entry) begin
      w_state_next = S_FAULT;
      w_timer_next = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_red_rise && (r_ped_wait || w_press)) begin
            w_state_next = S_WALK;
            w_timer_next = CNT_W'(WALK_CYC - 1);
          end
        end
        S_WALK: begin
          if (!i_red) begin
            w_state_next = S_IDLE;
            w_timer_next = '0;
          end else if (r_timer == '0) begin
            w_state_next = S_CLEAR;
            w_timer_next = CNT_W'(FLASH_CYC - 1);
          end else begin
            w_timer_next = r_timer - 1'b1;
          end
        end
        S_CLEAR: begin
          if (!i_red || r_timer == '0) begin
            w_state_next = S_IDLE;
            w_timer_next = '0;
          end else begin
            w_timer_next = r_timer - 1'b1;
          end
        end
        // Reaching here means the current cycle is legal
        S_FAULT: w_state_next = S_IDLE;
        default: begin
          w_state_next = S_IDLE;
          w_timer_next = '0;
        end
      endcase
    end
  end

  // Outputs are computed from the next state so they land with the state change
  always_comb begin
    w_walk_next      = (w_state_next == S_WALK);
    w_countdown_next = (w_state_next == S_CLEAR) ? w_timer_next + 1'b1 : '0;
    w_dont_walk_next = 1'b1;
    if (w_state_next == S_WALK)
      w_dont_walk_next = 1'b0;
    else if (w_state_next == S_CLEAR && r_state == S_CLEAR)
      w_dont_walk_next = ~r_dont_walk;
    w_ped_wait_next = r_ped_wait;
    if (w_state_next == S_FAULT)
      w_ped_wait_next = 1'b0;
    else if (w_state_next == S_WALK && r_state != S_WALK)
      w_ped_wait_next = 1'b0;
    else if (w_press && (r_state == S_IDLE || r_state == S_CLEAR))
      w_ped_wait_next = 1'b1;
    w_fault_next = r_fault | (w_state_next == S_FAULT);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_btn_d     <= 1'b0;
      r_red_d     <= 1'b0;
      r_bad_cnt   <= 2'd0;
      r_walk      <= 1'b0;
      r_dont_walk <= 1'b1;
      r_countdown <= '0;
      r_ped_wait  <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_timer     <= w_timer_next;
      r_sync1     <= i_ped_btn;
      r_sync2     <= r_sync1;
      r_btn_d     <= r_sync2;
      r_red_d     <= i_red;
      r_bad_cnt   <= w_bad_next;
      r_walk      <= w_walk_next;
      r_dont_walk <= w_dont_walk_next;
      r_countdown <= w_countdown_next;
      r_ped_wait  <= w_ped_wait_next;
      r_fault     <= w_fault_next;
    end
  end

  assign o_walk      = r_walk;
  assign o_dont_walk = r_dont_walk;
  assign o_countdown = r_countdown;
  assign o_ped_wait  = r_ped_wait;
  assign o_fault     = r_fault;

endmodule

// File: tb/tb_tlc_ped_ctrl.sv
// Directed bench for tlc_ped_ctrl: crossing, no-request, abort, fault, held button, reset.
module tb_tlc_ped_ctrl;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n, red, yellow, green, ped_btn;
  logic             walk, dont_walk, ped_wait, fault;
  logic [CNT_W-1:0] countdown;

  int n_cmp = 0;
  int n_err = 0;

  tlc_ped_ctrl #(.WALK_CYC(6), .FLASH_CYC(4), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_red(red), .i_yellow(yellow), .i_green(green),
    .i_ped_btn(ped_btn), .o_walk(walk), .o_dont_walk(dont_walk),
    .o_countdown(countdown), .o_ped_wait(ped_wait), .o_fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic lamps(input logic r, input logic y, input logic g);
    red = r; yellow = y; green = g;
  endtask

  // One-edge button pulse; ped_wait is visible after the third edge
  task automatic press_btn();
    ped_btn = 1'b1;
    step(1);
    ped_btn = 1'b0;
    step(2);
  endtask

  initial begin
    rst_n = 1'b0; ped_btn = 1'b0;
    lamps(0, 0, 1);
    #12;
    check("rst_walk", walk, 0);
    check("rst_dont_walk", dont_walk, 1);
    check("rst_countdown", countdown, 0);
    check("rst_ped_wait", ped_wait, 0);
    check("rst_fault", fault, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(2);

    // Button held 20 cycles during green: latency 3 edges, one request only
    ped_btn = 1'b1;
    step(1); check("btn_edge1", ped_wait, 0);
    step(1); check("btn_edge2", ped_wait, 0);
    step(1); check("btn_edge3", ped_wait, 1);
    step(17);
    ped_btn = 1'b0;
    step(3);
    check("held_still_wait", ped_wait, 1);

    // Normal crossing
    lamps(0, 1, 0);
    step(1);
    check("yellow_no_walk", walk, 0);
    lamps(1, 0, 0);
    step(1);
    check("walk_pw_clear", ped_wait, 0);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("walk_c%0d", i), walk, 1);
      check($sformatf("walk_dw_c%0d", i), dont_walk, 0);
      check($sformatf("walk_cd_c%0d", i), countdown, 0);
      step(1);
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("clr_walk_c%0d", i), walk, 0);
      check($sformatf("clr_dw_c%0d", i), dont_walk, (i % 2 == 0) ? 1 : 0);
      check($sformatf("clr_cd_c%0d", i), countdown, 4 - i);
      step(1);
    end
    check("idle_dw", dont_walk, 1);
    check("idle_cd", countdown, 0);
    check("idle_walk", walk, 0);

    // No request: red rise leaves the crossing closed
    lamps(0, 0, 1);
    step(3);
    lamps(1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(1);
      check($sformatf("noreq_walk_c%0d", i), walk, 0);
    end

    // Abort in third WALK cycle
    lamps(0, 0, 1);
    step(2);
    press_btn();
    check("abort_req", ped_wait, 1);
    lamps(1, 0, 0);
    step(1);
    check("abort_walk1", walk, 1);
    step(2);
    check("abort_walk3", walk, 1);
    lamps(0, 0, 1);
    step(1);
    check("abort_walk", walk, 0);
    check("abort_dw", dont_walk, 1);
    check("abort_cd", countdown, 0);

    // Press during WALK ignored; press during CLEAR serviced next red rise
    press_btn();
    check("req2", ped_wait, 1);
    lamps(1, 0, 0);
    step(1);
    check("req2_walk", walk, 1);
    ped_btn = 1'b1;
    step(1);
    ped_btn = 1'b0;
    step(2);
    check("walk_press_ignored", ped_wait, 0);
    step(1);
    check("walk_press_ignored2", ped_wait, 0);
    step(1);
    check("walk_last", walk, 1);
    ped_btn = 1'b1;
    step(1);
    ped_btn = 1'b0;
    check("clear_entry_cd", countdown, 4);
    step(1);
    check("clear_press_pending", ped_wait, 0);
    step(1);
    check("clear_press_latched", ped_wait, 1);
    step(2);
    check("after_clear_cd", countdown, 0);
    check("after_clear_pw", ped_wait, 1);
    lamps(0, 0, 1);
    step(2);
    lamps(1, 0, 0);
    step(1);
    check("serviced_walk", walk, 1);
    check("serviced_pw", ped_wait, 0);
    step(10);

    // Single illegal cycle never faults
    lamps(0, 0, 1);
    step(2);
    lamps(1, 0, 1);
    step(1);
    check("glitch_fault_a", fault, 0);
    lamps(0, 0, 1);
    step(1);
    check("glitch_fault_b", fault, 0);
    step(1);
    check("glitch_fault_c", fault, 0);

    // Two illegal cycles during WALK
    press_btn();
    lamps(1, 0, 0);
    step(2);
    check("pre_fault_walk", walk, 1);
    lamps(1, 0, 1);
    step(1);
    check("fault_1cyc_walk", walk, 1);
    check("fault_1cyc_flag", fault, 0);
    step(1);
    check("fault_flag", fault, 1);
    check("fault_walk", walk, 0);
    check("fault_dw", dont_walk, 1);
    check("fault_cd", countdown, 0);
    step(1);
    check("fault_hold", fault, 1);
    lamps(1, 0, 0);
    step(1);
    check("fault_sticky", fault, 1);
    check("fault_exit_dw", dont_walk, 1);
    press_btn();
    check("post_fault_idle_req", ped_wait, 1);

    // Asynchronous reset mid-WALK
    lamps(0, 0, 1);
    step(1);
    lamps(1, 0, 0);
    step(2);
    check("prerst_walk", walk, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_walk", walk, 0);
    check("arst_dw", dont_walk, 1);
    check("arst_cd", countdown, 0);
    check("arst_pw", ped_wait, 0);
    check("arst_fault", fault, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    lamps(0, 0, 1);
    step(2);
    press_btn();
    lamps(1, 0, 0);
    step(1);
    check("post_rst_walk", walk, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
